// File: rtl/hash_digest_sequencer.sv
// hash_digest_sequencer: latches a digest and feeds it to the hex converter MSB nibble first, then CR and LF, paced by the UART handshake
module hash_digest_sequencer #(
    parameter int DIGEST_BITS = 256,
    parameter int CNT_W = 7
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic [DIGEST_BITS-1:0] Digest,
    input  logic                   TxDone,
    output logic [3:0]             HexOut,
    output logic                   ConvEn,
    output logic                   SendCR,
    output logic                   SendLF,
    output logic                   TxStart,
    output logic                   Busy,
    output logic                   Done
);
    localparam int NIBBLES = DIGEST_BITS / 4;
    localparam logic [CNT_W-1:0] CR_IDX = CNT_W'(NIBBLES);
    localparam logic [CNT_W-1:0] LF_IDX = CNT_W'(NIBBLES + 1);

    typedef enum logic [2:0] {IDLE, PRESENT, SEND, WAIT, FINISH} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nx;
    logic [DIGEST_BITS-1:0] dig;
    logic [DIGEST_BITS-1:0] dig_sh;

    assign cnt_nx = cnt + CNT_W'(1);
    assign dig_sh = dig << 4;

    // Sequencer; strobes are decoded from the state being entered so they line up with it
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            dig     <= '0;
            HexOut  <= '0;
            ConvEn  <= 1'b0;
            SendCR  <= 1'b0;
            SendLF  <= 1'b0;
            TxStart <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            HexOut  <= '0;
            ConvEn  <= 1'b0;
            SendCR  <= 1'b0;
            SendLF  <= 1'b0;
            TxStart <= 1'b0;
            Done    <= 1'b0;
            case (state)
                IDLE: begin
                    Busy <= Start;
                    if (Start) begin
                        dig    <= Digest;
                        cnt    <= '0;
                        state  <= PRESENT;
                        ConvEn <= 1'b1;
                        HexOut <= Digest[DIGEST_BITS-1 -: 4];
                    end
                end
                PRESENT: begin
                    state   <= SEND;
                    TxStart <= 1'b1;
                end
                SEND: state <= WAIT;
                WAIT: begin
                    if (TxDone) begin
                        if (cnt == LF_IDX) begin
                            state <= FINISH;
                            Done  <= 1'b1;
                        end else begin
                            state  <= PRESENT;
                            cnt    <= cnt_nx;
                            ConvEn <= 1'b1;
                            if (cnt < CR_IDX) dig <= dig_sh;
                            HexOut <= (cnt_nx < CR_IDX) ? dig_sh[DIGEST_BITS-1 -: 4] : 4'h0;
                            SendCR <= cnt_nx == CR_IDX;
                            SendLF <= cnt_nx == LF_IDX;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/hash_digest_sequencer.md
Name: hash_digest_sequencer

Overview:
Sits directly upstream of the hex-nibble-to-ASCII converter. It latches a finished SHA-256 digest and presents it to the converter one nibble at a time, most significant nibble first. After the last nibble it requests a Carriage Return, then a Line Feed, and it paces each character against the UART transmitter using a start/done handshake. It signals Done once the full line has been transmitted.

Parameters:
DIGEST_BITS, 256, digest width in bits; must be a multiple of 4; NIBBLES = DIGEST_BITS/4.
CNT_W, 7, width of the character counter; must satisfy 2^CNT_W > NIBBLES+1.

Ports:
Clk  in  1  system clock; all logic on rising edge.
Reset  in  1  asynchronous, active-low reset.
Start  in  1  request to transmit Digest; sampled only in IDLE.
Digest  in  DIGEST_BITS  hash value; captured on the accepted Start cycle.
TxDone  in  1  one-cycle pulse from the UART transmitter when a frame has finished.
HexOut  out  4  nibble presented to the converter.
ConvEn  out  1  converter enable; high for exactly one cycle per character.
SendCR  out  1  converter CR request; qualified by ConvEn.
SendLF  out  1  converter LF request; qualified by ConvEn.
TxStart  out  1  one-cycle pulse telling the UART to send the converter's registered output.
Busy  out  1  high from the cycle after Start is accepted through FINISH inclusive.
Done  out  1  one-cycle pulse after the LF frame completes.

Behaviour:
- Reset (async, Reset=0) sets:
  - HexOut=0, ConvEn=0, SendCR=0, SendLF=0, TxStart=0, Busy=0, Done=0.
  - State=IDLE, character counter=0, digest register=0.
- All outputs are registered. They are decoded from the next state and counter so that they are valid in the cycle the state is occupied.
- States: IDLE, PRESENT, SEND, WAIT, FINISH.
- IDLE:
  - On Start=1, latch Digest into the shift register, clear the counter and go to PRESENT.
  - Otherwise stay in IDLE.
- PRESENT (1 cycle):
  - ConvEn=1.
  - If counter<NIBBLES: HexOut = top nibble of the shift register, SendCR=0, SendLF=0.
  - If counter==NIBBLES: HexOut=0, SendCR=1.
  - If counter==NIBBLES+1: HexOut=0, SendLF=1.
  - Always go to SEND.
- SEND (1 cycle):
  - ConvEn=0 and TxStart=1. The converter output registered at the end of PRESENT is now stable.
  - Go to WAIT.
- WAIT:
  - All strobes are low.
  - Stay in WAIT until TxDone=1.
  - On TxDone, if counter==NIBBLES+1, go to FINISH.
  - Otherwise increment the counter, shift the digest register left by 4 when counter<NIBBLES, and go to PRESENT.
- FINISH (1 cycle): Done=1, Busy=1; then go to IDLE.
- Character order: nibble DIGEST_BITS-1:DIGEST_BITS-4 first, through nibble 3:0, then CR, then LF. A full line is NIBBLES+2 characters (66 at the default).
- Latency:
  - Start is accepted at cycle 0, PRESENT is cycle 1 and the first TxStart is cycle 2.
  - After each TxDone, the next PRESENT follows on the next cycle.
- Boundary conditions:
  - Start outside IDLE (including during FINISH) is ignored. The digest register is not disturbed.
  - TxDone outside WAIT is ignored, including TxDone in the same cycle as TxStart.
  - Digest changes after the Start cycle have no effect.
  - Reset asserted mid-line returns to IDLE immediately with all outputs 0. No Done is generated, and the next Start restarts from nibble 0.
  - Start held high continuously results in back-to-back lines. Each line begins only after the FINISH cycle returns to IDLE.
  - The counter never exceeds NIBBLES+1, so there is no wrap-around.

Test Plan:
- Default params, Digest=0x0123456789abcdef repeated 4 times, TxDone 3 cycles after each TxStart -> 66 TxStart pulses. HexOut sequence is 0,1,...,f repeated 4 times, then SendCR on the 65th ConvEn and SendLF on the 66th. Done pulses once, 1 cycle after the 66th TxDone. Busy falls the cycle after Done.
- Start at cycle 0 -> ConvEn=1 in cycle 1, TxStart=1 in cycle 2. Hold TxDone low for 100 cycles -> no further ConvEn/TxStart and state stays WAIT.
- Start pulsed and Digest changed to 0xffff...ff during character 10 -> both ignored, and the remaining nibbles match the original digest.
- Spurious TxDone in IDLE and in the TxStart cycle -> no state change, no extra ConvEn.
- Reset low during WAIT of character 30 -> all outputs 0 within the reset cycle, no Done. A new Start transmits from the top nibble again.
- DIGEST_BITS=8, Digest=0xa5 -> characters a, 5, CR, LF (4 TxStart pulses), then one Done pulse.
